// File: rtl/mc_fifo_rr.sv
// Multi-channel FIFO: per-channel queues behind one tagged input port, drained
// round-robin through a registered output stage. Optional MC_FIFO_RR_WATERMARK_EN adds wmark_o.
module mc_fifo_rr #(
   parameter int WIDTH        = 32,
   parameter int LOG_DEPTH    = 2,
   parameter int NUM_CHANNELS = 4,
   localparam int CHAN_W      = $clog2(NUM_CHANNELS)
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  in_valid_i,
   output logic                                  in_ready_o,
   input  logic [CHAN_W-1:0]                     in_chan_i,
   input  logic [WIDTH-1:0]                      in_data_i,
   output logic                                  out_valid_o,
   input  logic                                  out_ready_i,
   output logic [CHAN_W-1:0]                     out_chan_o,
   output logic [WIDTH-1:0]                      out_data_o,
   input  logic [NUM_CHANNELS-1:0]               flush_i,
   output logic [NUM_CHANNELS*(LOG_DEPTH+1)-1:0] usage_o
`ifdef MC_FIFO_RR_WATERMARK_EN
   ,
   output logic [NUM_CHANNELS*(LOG_DEPTH+1)-1:0] wmark_o
`endif
);

   localparam int DEPTH     = 2**LOG_DEPTH;
   localparam int PW        = LOG_DEPTH + 1;
   localparam int CHAN_SPAN = 2**CHAN_W;

   typedef logic [PW-1:0] ptr_t;

   logic [WIDTH-1:0]         mem_q [NUM_CHANNELS][DEPTH];
   ptr_t                     wptr_q [NUM_CHANNELS];
   ptr_t                     wptr_d [NUM_CHANNELS];
   ptr_t                     rptr_q [NUM_CHANNELS];
   ptr_t                     rptr_d [NUM_CHANNELS];
   ptr_t                     usage  [NUM_CHANNELS];

   logic [NUM_CHANNELS-1:0]  empty, full, req, wr_en, rd_en;
   logic [CHAN_SPAN-1:0]     ready_vec;
   logic                     wr_any;
   logic                     load;

   logic [CHAN_W-1:0]        rr_q;
   logic [CHAN_W-1:0]        grant;
   logic                     grant_vld;
   logic [CHAN_W:0]          arb_idx;
   logic [WIDTH-1:0]         head_data;

   logic                     out_valid_q;
   logic [CHAN_W-1:0]        out_chan_q;
   logic [WIDTH-1:0]         out_data_q;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
         assign empty[gi] = (wptr_q[gi] == rptr_q[gi]);
         assign full[gi]  = ((wptr_q[gi] ^ rptr_q[gi]) == {1'b1, {LOG_DEPTH{1'b0}}});
         assign req[gi]   = !empty[gi] & !flush_i[gi];
         assign usage[gi] = wptr_q[gi] - rptr_q[gi];
         assign usage_o[gi*PW +: PW] = usage[gi];
         assign wr_en[gi] = in_valid_i & in_ready_o & (in_chan_i == CHAN_W'(gi));
         assign rd_en[gi] = load & grant_vld & (grant == CHAN_W'(gi));
      end
      // Unused channel codes read as ready so stray words are swallowed.
      for (gi = 0; gi < CHAN_SPAN; gi++) begin : g_ready
         if (gi < NUM_CHANNELS) begin : g_real
            assign ready_vec[gi] = !full[gi] & !flush_i[gi];
         end else begin : g_pad
            assign ready_vec[gi] = 1'b1;
         end
      end
   endgenerate

   assign in_ready_o = ready_vec[in_chan_i];
   assign wr_any     = |wr_en;
   assign load       = !out_valid_q | out_ready_i;

   always_comb begin
      grant     = rr_q;
      grant_vld = 1'b0;
      arb_idx   = '0;
      for (int i = 1; i <= NUM_CHANNELS; i++) begin
         arb_idx = {1'b0, rr_q} + (CHAN_W+1)'(i);
         if (arb_idx >= (CHAN_W+1)'(NUM_CHANNELS))
            arb_idx = arb_idx - (CHAN_W+1)'(NUM_CHANNELS);
         if (!grant_vld && req[arb_idx[CHAN_W-1:0]]) begin
            grant_vld = 1'b1;
            grant     = arb_idx[CHAN_W-1:0];
         end
      end
   end

   assign head_data = mem_q[grant][rptr_q[grant][LOG_DEPTH-1:0]];

   // Flush snaps rptr to the pre-edge wptr; no write can land on a flushing channel.
   always_comb begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         wptr_d[c] = wptr_q[c] + PW'(wr_en[c]);
         rptr_d[c] = flush_i[c] ? wptr_q[c] : rptr_q[c] + PW'(rd_en[c]);
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_any)
         mem_q[in_chan_i][wptr_q[in_chan_i][LOG_DEPTH-1:0]] <= in_data_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            wptr_q[c] <= '0;
            rptr_q[c] <= '0;
         end
         rr_q        <= '0;
         out_valid_q <= 1'b0;
         out_chan_q  <= '0;
         out_data_q  <= '0;
      end else begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            wptr_q[c] <= wptr_d[c];
            rptr_q[c] <= rptr_d[c];
         end
         if (load) begin
            out_valid_q <= grant_vld;
            if (grant_vld) begin
               out_chan_q <= grant;
               out_data_q <= head_data;
               rr_q       <= grant;
            end
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_chan_o  = out_chan_q;
   assign out_data_o  = out_data_q;

`ifdef MC_FIFO_RR_WATERMARK_EN
   ptr_t wmark_q [NUM_CHANNELS];
   ptr_t usage_d [NUM_CHANNELS];

   always_comb begin
      for (int c = 0; c < NUM_CHANNELS; c++)
         usage_d[c] = wptr_d[c] - rptr_d[c];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int c = 0; c < NUM_CHANNELS; c++)
            wmark_q[c] <= '0;
      end else begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (flush_i[c])
               wmark_q[c] <= '0;
            else if (usage_d[c] > wmark_q[c])
               wmark_q[c] <= usage_d[c];
         end
      end
   end

   generate
      for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_wmark
         assign wmark_o[gi*PW +: PW] = wmark_q[gi];
      end
   endgenerate
`endif

endmodule

// File: tb/tb_mc_fifo_rr.sv
// Directed bench for mc_fifo_rr: fill/full, round-robin order, streaming,
// flush, async reset, and (when MC_FIFO_RR_WATERMARK_EN is defined) watermarks.
module tb_mc_fifo_rr;
   localparam int WIDTH        = 32;
   localparam int LOG_DEPTH    = 2;
   localparam int NUM_CHANNELS = 4;
   localparam int CHAN_W       = 2;
   localparam int PW           = LOG_DEPTH + 1;

   logic                        clk_i = 1'b0;
   logic                        rst_i = 1'b1;
   logic                        in_valid_i;
   logic                        in_ready_o;
   logic [CHAN_W-1:0]           in_chan_i;
   logic [WIDTH-1:0]            in_data_i;
   logic                        out_valid_o;
   logic                        out_ready_i;
   logic [CHAN_W-1:0]           out_chan_o;
   logic [WIDTH-1:0]            out_data_o;
   logic [NUM_CHANNELS-1:0]     flush_i;
   logic [NUM_CHANNELS*PW-1:0]  usage_o;
`ifdef MC_FIFO_RR_WATERMARK_EN
   logic [NUM_CHANNELS*PW-1:0]  wmark_o;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   mc_fifo_rr #(
      .WIDTH        (WIDTH),
      .LOG_DEPTH    (LOG_DEPTH),
      .NUM_CHANNELS (NUM_CHANNELS)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_chan_i   (in_chan_i),
      .in_data_i   (in_data_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_chan_o  (out_chan_o),
      .out_data_o  (out_data_o),
      .flush_i     (flush_i),
      .usage_o     (usage_o)
`ifdef MC_FIFO_RR_WATERMARK_EN
      ,
      .wmark_o     (wmark_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("ok   %s = 0x%0h", tag, got);
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [PW-1:0] usage_of(input int c);
      return usage_o[c*PW +: PW];
   endfunction

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic write(input int ch, input logic [WIDTH-1:0] d);
      in_valid_i = 1'b1;
      in_chan_i  = CHAN_W'(ch);
      in_data_i  = d;
      cyc();
      in_valid_i = 1'b0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      cyc();
      rst_i = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      logic [WIDTH-1:0] exp_data [5];
      logic [CHAN_W-1:0] exp_chan [5];

      in_valid_i  = 1'b0;
      in_chan_i   = '0;
      in_data_i   = '0;
      out_ready_i = 1'b0;
      flush_i     = '0;
      repeat (2) @(posedge clk_i);
      #1;

      // Reset state
      check("rst_out_valid", 64'(out_valid_o), 64'd0);
      check("rst_out_chan",  64'(out_chan_o),  64'd0);
      check("rst_out_data",  64'(out_data_o),  64'd0);
      check("rst_usage",     64'(usage_o),     64'd0);
      rst_i = 1'b0;

      // Fill ch2 with the output stalled
      write(2, 32'hA0);
      check("lat_no_fallthru", 64'(out_valid_o), 64'd0);
      write(2, 32'hA1);
      write(2, 32'hA2);
      write(2, 32'hA3);
      check("fill_usage2_3", 64'(usage_of(2)), 64'd3);
      check("fill_out_valid", 64'(out_valid_o), 64'd1);
      check("fill_out_data",  64'(out_data_o),  64'hA0);
      check("fill_out_chan",  64'(out_chan_o),  64'd2);
      write(2, 32'hA4);
      check("fill_usage2_4", 64'(usage_of(2)), 64'd4);
      in_chan_i = 2'd2;
      #2;
      check("full_ready_ch2", 64'(in_ready_o), 64'd0);
      in_chan_i = 2'd0;
      #2;
      check("full_ready_ch0", 64'(in_ready_o), 64'd1);
      check("stall_hold_data", 64'(out_data_o), 64'hA0);
      out_ready_i = 1'b1;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("drain2_valid_%0d", k), 64'(out_valid_o), 64'd1);
         check($sformatf("drain2_data_%0d", k),  64'(out_data_o),  64'(32'hA0 + k));
         cyc();
      end
      check("drain2_empty", 64'(out_valid_o), 64'd0);
      check("drain2_usage", 64'(usage_of(2)), 64'd0);

      // Round-robin order across channels, starting from a fresh RR pointer
      out_ready_i = 1'b0;
      do_reset();
      write(0, 32'h10);
      write(0, 32'h11);
      write(1, 32'h20);
      write(1, 32'h21);
      write(3, 32'h30);
      exp_data = '{32'h10, 32'h20, 32'h30, 32'h11, 32'h21};
      exp_chan = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1};
      out_ready_i = 1'b1;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("rr_valid_%0d", k), 64'(out_valid_o), 64'd1);
         check($sformatf("rr_data_%0d", k),  64'(out_data_o),  64'(exp_data[k]));
         check($sformatf("rr_chan_%0d", k),  64'(out_chan_o),  64'(exp_chan[k]));
         cyc();
      end
      check("rr_empty", 64'(out_valid_o), 64'd0);

      // Back-to-back streaming on ch1
      in_valid_i = 1'b1;
      in_chan_i  = 2'd1;
      for (int k = 0; k < 64; k++) begin
         in_data_i = 32'h100 + 32'(k);
         #2;
         check($sformatf("stream_ready_%0d", k), 64'(in_ready_o), 64'd1);
         cyc();
         if (k >= 1) begin
            check($sformatf("stream_valid_%0d", k), 64'(out_valid_o), 64'd1);
            check($sformatf("stream_data_%0d", k), 64'(out_data_o), 64'(32'h100 + 32'(k - 1)));
            check($sformatf("stream_usage_%0d", k), 64'(usage_of(1) <= 3'd1), 64'd1);
         end
      end
      in_valid_i = 1'b0;
      cyc();
      check("stream_last", 64'(out_data_o), 64'h13F);
      cyc();
      check("stream_done", 64'(out_valid_o), 64'd0);

      // Flush ch3 while its head sits in the output register
      out_ready_i = 1'b0;
      write(3, 32'h40);
      write(3, 32'h41);
      write(3, 32'h42);
      write(3, 32'h43);
      check("flush_pre_usage3", 64'(usage_of(3)), 64'd3);
      flush_i    = 4'b1000;
      in_valid_i = 1'b1;
      in_chan_i  = 2'd3;
      in_data_i  = 32'h99;
      #2;
      check("flush_ready_ch3", 64'(in_ready_o), 64'd0);
      cyc();
      flush_i    = '0;
      in_valid_i = 1'b0;
      check("flush_usage3",     64'(usage_of(3)), 64'd0);
      check("flush_out_valid",  64'(out_valid_o), 64'd1);
      check("flush_out_data",   64'(out_data_o),  64'h40);
      check("flush_out_chan",   64'(out_chan_o),  64'd3);
      out_ready_i = 1'b1;
      cyc();
      check("flush_after_hs", 64'(out_valid_o), 64'd0);
      check("flush_drop_write", 64'(usage_of(3)), 64'd0);

      // Asynchronous reset between clock edges
      out_ready_i = 1'b0;
      write(0, 32'h50);
      write(0, 32'h51);
      check("arst_pre_valid", 64'(out_valid_o), 64'd1);
      check("arst_pre_usage0", 64'(usage_of(0)), 64'd1);
      #3;
      rst_i = 1'b1;
      #1;
      check("arst_out_valid", 64'(out_valid_o), 64'd0);
      check("arst_usage",     64'(usage_o),     64'd0);
      cyc();
      rst_i = 1'b0;
      write(0, 32'h60);
      check("arst_lat", 64'(out_valid_o), 64'd0);
      cyc();
      check("arst_first_valid", 64'(out_valid_o), 64'd1);
      check("arst_first_data",  64'(out_data_o),  64'h60);
      out_ready_i = 1'b1;
      cyc();
      check("arst_no_stale", 64'(out_valid_o), 64'd0);

`ifdef MC_FIFO_RR_WATERMARK_EN
      // Watermark: park a ch1 word in the output so ch0 storage can reach 3
      out_ready_i = 1'b0;
      do_reset();
      write(1, 32'h80);
      write(0, 32'h70);
      write(0, 32'h71);
      write(0, 32'h72);
      check("wm_usage0", 64'(usage_of(0)), 64'd3);
      out_ready_i = 1'b1;
      repeat (5) cyc();
      check("wm_drained", 64'(out_valid_o), 64'd0);
      check("wm_ch0_max", 64'(wmark_o[0 +: PW]), 64'd3);
      flush_i = 4'b0001;
      cyc();
      flush_i = '0;
      check("wm_ch0_clear", 64'(wmark_o[0 +: PW]), 64'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mc_fifo_rr.md
Name: mc_fifo_rr

Overview:
- Single-clock, multi-channel FIFO.
- NUM_CHANNELS independent queues of 2**LOG_DEPTH entries each share one input port (channel-tagged) and one output port.
- Output is fed by a round-robin arbiter through a registered output stage.
- Sits in front of shared consumers (DMA engines, bus bridges) to decouple several producers' streams, with per-channel flush and fill-level visibility.

Parameters:
- WIDTH, 32, payload width in bits.
- LOG_DEPTH, 2, per-channel depth is 2**LOG_DEPTH; must be >= 1.
- NUM_CHANNELS, 4, number of queues; must be >= 2.
- CHAN_W, $clog2(NUM_CHANNELS), channel index width (derived, not overridable).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- in_valid_i  in  1  input word valid
- in_ready_o  out  1  input accepted when in_valid_i & in_ready_o
- in_chan_i  in  CHAN_W  destination queue of input word
- in_data_i  in  WIDTH  input payload
- out_valid_o  out  1  output word valid
- out_ready_i  in  1  consumer ready
- out_chan_o  out  CHAN_W  queue the output word came from
- out_data_o  out  WIDTH  output payload
- flush_i  in  NUM_CHANNELS  per-channel synchronous flush
- usage_o  out  NUM_CHANNELS*(LOG_DEPTH+1)  per-channel entry count in storage; channel c at bits [c*(LOG_DEPTH+1) +: LOG_DEPTH+1]

Interface decision: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset (rst_i=1):
  - All pointers cleared; output register empty.
  - out_valid_o=0, out_chan_o=0, out_data_o=0, usage_o=0, RR pointer=0.
  - Storage contents are not reset.
- Per-channel pointers are LOG_DEPTH+1 bits, binary, and wrap naturally.
  - Empty: wptr==rptr.
  - Full: pointers differ only in the MSB.
- in_ready_o = !full[in_chan_i] & !flush_i[in_chan_i].
  - Combinational from in_chan_i; must not depend on in_valid_i.
  - in_chan_i >= NUM_CHANNELS: in_ready_o=1 and the word is silently dropped.
- Output stage: a single register.
  - Loads when empty or when out_valid_o & out_ready_i (full throughput, 1 word/cycle).
  - Load source: the arbitration winner among non-empty, non-flushing channels.
- Arbitration:
  - Round-robin, searching from the channel after the last grant.
  - The RR pointer updates only on an actual load.
- Latency: a word accepted at edge k can appear on out_valid_o no earlier than after edge k+1.
  - No fall-through from input to output.
- AXI-style stability:
  - Once out_valid_o=1, out_data_o and out_chan_o hold until handshake.
  - out_valid_o never drops without a handshake, except under reset.
- Same-cycle write and read on one channel: both take effect; usage unchanged.
  - A full channel stays not-ready that cycle, because in_ready_o does not look ahead.
- usage_o[c] = wptr - rptr for storage only; the word in the output register is not counted.
- flush_i[c]:
  - At the next edge, rptr[c] is set to wptr[c] (channel becomes empty).
  - No write to c in the same cycle.
  - c is excluded from arbitration that cycle.
  - A word from c already in the output register is NOT revoked; it completes normally.
- Multiple flush bits may be set simultaneously; each acts independently.

Optional Feature:
- Macro: MC_FIFO_RR_WATERMARK_EN.
- When defined:
  - Extra output port wmark_o, NUM_CHANNELS*(LOG_DEPTH+1) bits, same packing as usage_o.
  - Per channel, a register tracks the maximum usage_o value seen since reset or flush of that channel.
  - Updated every cycle with the post-edge usage.
  - Reset to 0; cleared to 0 by flush_i[c].
  - Saturates naturally at 2**LOG_DEPTH.
- When undefined: port and registers absent; all other behaviour identical.

Test Plan:
- Reset, then 4 words 0xA0..0xA3 to chan 2 with out_ready_i=0:
  - usage ch2 reaches 3 while one word sits in the output register, and out_valid_o=1.
  - Out data 0xA0, chan 2.
  - After a 5th write fills ch2 storage (usage=4), in_ready_o=0 for chan 2 and 1 for chan 0.
- Fill ch0 with 0x10,0x11 and ch1 with 0x20,0x21, and ch3 with 0x30; hold out_ready_i=1:
  - Output order is 0x10,0x20,0x30,0x11,0x21, one per cycle, no bubbles.
- Back-to-back streaming on ch1 with out_ready_i=1 for 64 cycles:
  - In-order output, throughput 1/cycle after the 2-cycle initial latency.
  - usage ch1 stays at or below 1.
- With ch3 holding 3 words and its head in the output register, pulse flush_i[3] with out_ready_i=0:
  - usage ch3 becomes 0; out_valid_o remains 1 with the head word.
  - After handshake, out_valid_o=0.
  - A write to ch3 during the flush cycle sees in_ready_o=0.
- Assert rst_i asynchronously mid-stream, between clock edges:
  - out_valid_o and usage_o go to 0 immediately.
  - After release, the first output is a newly written word.
- With MC_FIFO_RR_WATERMARK_EN: write 3 words to ch0, drain all:
  - wmark ch0 reads 3; flush_i[0] then clears it to 0.
